// File: rtl/dts_pack_streams.sv
// Packs 12-bit ADC samples into {top, middle, bottom} deformatted words, 3-bit or 8-bit split.
// Latency: word registered on the edge accepting its last chunk. No backpressure; dout holds until next word.
module dts_pack_streams #(
    parameter int INPUT_WIDTH = 128,
    parameter int NSAMP       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     is_three_bit,
    input  logic [12*NSAMP-1:0]      din,
    input  logic                     din_valid,
    input  logic                     sync,
    output logic [3*INPUT_WIDTH-1:0] dout,
    output logic                     dout_valid,
    output logic                     sync_out
);
    localparam int W  = INPUT_WIDTH;
    localparam int S8 = 4 * NSAMP;
    localparam int C3 = W / NSAMP;
    localparam int C8 = W / S8;
    localparam int CW = $clog2(C3 + 1);

    logic [W-1:0]   top_q, top_d, mid_q, mid_d, bot_q, bot_d;
    logic [W-1:0]   top_base, mid_base, bot_base, top_sh, mid_sh, bot_sh;
    logic [3*W-1:0] dout_q, dout_d;
    logic           dout_valid_q, dout_valid_d, sync_out_q, sync_out_d;
    logic           mode_q, mode_d, pend_q, pend_d;
    logic [CW-1:0]  fill_q, fill_d, chunks;
    logic           sync_acc, eff_mode;
    logic [NSAMP-1:0] c3_top, c3_mid, c3_bot;
    logic [S8-1:0]    c8_top, c8_bot;

    // Sample k lives at din[12*(NSAMP-1-k) +: 12]; earliest sample lands at the chunk MSB.
    always_comb begin
        c3_top = '0;
        c3_mid = '0;
        c3_bot = '0;
        c8_top = '0;
        c8_bot = '0;
        for (int k = 0; k < NSAMP; k++) begin
            c3_top[NSAMP-1-k] = din[12*(NSAMP-1-k) + 2];
            c3_mid[NSAMP-1-k] = din[12*(NSAMP-1-k) + 1];
            c3_bot[NSAMP-1-k] = din[12*(NSAMP-1-k)];
        end
        for (int j = 0; j < NSAMP/2; j++) begin
            c8_bot[S8-1-8*j -: 8] = din[12*(NSAMP-1-2*j) + 4 +: 8];
            c8_top[S8-1-8*j -: 8] = din[12*(NSAMP-2-2*j) + 4 +: 8];
        end
    end

    always_comb begin
        sync_acc = din_valid & sync;
        eff_mode = (sync_acc || fill_q == '0) ? is_three_bit : mode_q;
        chunks   = eff_mode ? CW'(C3) : CW'(C8);
        // A sync discards the partial word, so the new chunk shifts into a cleared register.
        top_base = sync_acc ? '0 : top_q;
        mid_base = sync_acc ? '0 : mid_q;
        bot_base = sync_acc ? '0 : bot_q;
        if (eff_mode) begin
            top_sh = {top_base[W-NSAMP-1:0], c3_top};
            mid_sh = {mid_base[W-NSAMP-1:0], c3_mid};
            bot_sh = {bot_base[W-NSAMP-1:0], c3_bot};
        end else begin
            top_sh = {top_base[W-S8-1:0], c8_top};
            mid_sh = {mid_base[W-S8-1:0], {S8{1'b0}}};
            bot_sh = {bot_base[W-S8-1:0], c8_bot};
        end
    end

    always_comb begin
        top_d        = top_q;
        mid_d        = mid_q;
        bot_d        = bot_q;
        mode_d       = mode_q;
        fill_d       = fill_q;
        pend_d       = pend_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        sync_out_d   = 1'b0;
        if (din_valid) begin
            top_d  = top_sh;
            mid_d  = mid_sh;
            bot_d  = bot_sh;
            mode_d = eff_mode;
            if (sync_acc) begin
                fill_d = (chunks == CW'(1)) ? '0 : CW'(1);
                pend_d = 1'b1;
            end else if (fill_q == chunks - CW'(1)) begin
                dout_d       = {top_sh, mid_sh, bot_sh};
                dout_valid_d = 1'b1;
                sync_out_d   = pend_q;
                pend_d       = 1'b0;
                fill_d       = '0;
            end else begin
                fill_d = fill_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top_q        <= '0;
            mid_q        <= '0;
            bot_q        <= '0;
            mode_q       <= 1'b1;
            fill_q       <= '0;
            pend_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sync_out_q   <= 1'b0;
        end else begin
            top_q        <= top_d;
            mid_q        <= mid_d;
            bot_q        <= bot_d;
            mode_q       <= mode_d;
            fill_q       <= fill_d;
            pend_q       <= pend_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sync_out_q   <= sync_out_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign sync_out   = sync_out_q;
endmodule
